// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the word-addressed PC, issues credit-limited in-order
// requests to a variable-latency instruction memory and buffers returned words for decode.
module fetch_unit #(
  parameter logic [24:0] RESET_PC = 25'd0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [24:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [24:0] redirect_pc,
  input  logic        n_stall,
  input  logic        dec_nstall,
  output logic [31:0] inst,
  output logic [24:0] if_pc,
  output logic        if_valid
);

  localparam int           AW      = $clog2(DEPTH);
  localparam int           CW      = AW + 1;
  localparam logic [CW:0]  DEPTH_W = (CW+1)'(DEPTH);

  logic [24:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;

  logic [24:0]   pend_mem [DEPTH];
  logic [AW-1:0] pend_wr;
  logic [AW-1:0] pend_rd;

  logic [31:0]   buf_data [DEPTH];
  logic [24:0]   buf_pc   [DEPTH];
  logic [AW-1:0] buf_wr;
  logic [AW-1:0] buf_rd;
  logic [CW-1:0] buf_count;

  logic          issue;
  logic          resp;
  logic          keep;
  logic          fire;
  logic [CW-1:0] out_after_resp;

  // Credit counts every in-flight request, stale ones included, so the buffer can never overflow.
  always_comb begin
    imem_req       = rst && !redirect &&
                     (({1'b0, outstanding} + {1'b0, buf_count}) < DEPTH_W);
    imem_addr      = fetch_pc;
    issue          = imem_req && imem_ack;
    resp           = imem_rvalid && (outstanding != '0);
    keep           = resp && (discard == '0) && !redirect;
    if_valid       = (buf_count != '0);
    fire           = if_valid && n_stall && dec_nstall && !redirect;
    out_after_resp = outstanding - CW'(resp);
    inst           = if_valid ? buf_data[buf_rd] : 32'h0;
    if_pc          = if_valid ? buf_pc[buf_rd]   : 25'h0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      pend_wr     <= '0;
      pend_rd     <= '0;
      buf_wr      <= '0;
      buf_rd      <= '0;
      buf_count   <= '0;
    end else if (redirect) begin
      // Everything still in flight after this cycle's response becomes stale.
      fetch_pc    <= redirect_pc;
      outstanding <= out_after_resp;
      discard     <= out_after_resp;
      pend_wr     <= '0;
      pend_rd     <= '0;
      buf_wr      <= '0;
      buf_rd      <= '0;
      buf_count   <= '0;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + 25'd1;
        pend_wr  <= pend_wr + AW'(1);
      end
      outstanding <= out_after_resp + CW'(issue);
      if (resp && (discard != '0)) begin
        discard <= discard - CW'(1);
      end
      if (keep) begin
        pend_rd <= pend_rd + AW'(1);
        buf_wr  <= buf_wr + AW'(1);
      end
      if (fire) begin
        buf_rd <= buf_rd + AW'(1);
      end
      buf_count <= buf_count + CW'(keep) - CW'(fire);
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      pend_mem[pend_wr] <= fetch_pc;
    end
    if (keep) begin
      buf_data[buf_wr] <= imem_rdata;
      buf_pc[buf_wr]   <= pend_mem[pend_rd];
    end
  end

  // A response with nothing outstanding is a memory protocol violation.
  always_ff @(posedge clk) begin
    if (rst && imem_rvalid) begin
      assert (outstanding != '0);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-configurable memory model plus a queue of
// expected decode-side PCs that is refilled whenever the stream is redirected.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [24:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [24:0] redirect_pc;
  logic        n_stall;
  logic        dec_nstall;
  logic [31:0] inst;
  logic [24:0] if_pc;
  logic        if_valid;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(25'd0), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .n_stall     (n_stall),
    .dec_nstall  (dec_nstall),
    .inst        (inst),
    .if_pc       (if_pc),
    .if_valid    (if_valid)
  );

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          fires = 0;
  int          lat = 1;
  int          last_due = 0;
  int          base;
  bit          ack_rand = 1'b0;
  logic        want_rst = 1'b0;
  logic        want_dec_nstall = 1'b1;
  logic [24:0] exp_issue_pc = 25'd0;
  logic [24:0] exp_q[$];
  logic [24:0] mem_addr_q[$];
  int          mem_due_q[$];

  function automatic logic [31:0] word(input logic [24:0] a);
    return {7'd0, a} | 32'hA500_0000;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic refill(input logic [24:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 25'(i));
  endtask

  // One clock: drive at the falling edge, then sample and score before the rising edge.
  task automatic apply_stimulus(input logic rd, input logic [24:0] rpc);
    logic [24:0] e;
    int          due;
    @(negedge clk);
    cyc++;
    rst         = want_rst;
    dec_nstall  = want_dec_nstall;
    n_stall     = 1'b1;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ack    = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mem_addr_q.size() != 0 && mem_due_q[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word(mem_addr_q[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    if (rd) begin
      refill(rpc);
      exp_issue_pc = rpc;
    end
    #1;
    if (rd) check_output("req_in_redirect", 32'(imem_req), 32'd0);
    if (imem_req && imem_ack) begin
      check_output("issue_addr", 32'(imem_addr), 32'(exp_issue_pc));
      exp_issue_pc++;
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_addr_q.push_back(imem_addr);
      mem_due_q.push_back(due);
    end
    if (imem_rvalid) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (!rd && if_valid && n_stall && dec_nstall) begin
      fires++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_underflow observed=%h expected=none", if_pc);
      end else begin
        e = exp_q.pop_front();
        check_output("sb_pc", 32'(if_pc), 32'(e));
        check_output("sb_inst", inst, word(e));
      end
    end
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int n = 0;
    while (fires < target && n < budget) begin
      apply_stimulus(1'b0, 25'd0);
      n++;
    end
    check_output(tag, 32'(fires >= target), 32'd1);
  endtask

  initial begin
    rst = 1'b0; imem_ack = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 25'd0; n_stall = 1'b1; dec_nstall = 1'b1;
    refill(25'd0);

    // Reset state
    apply_stimulus(1'b0, 25'd0);
    apply_stimulus(1'b0, 25'd0);
    check_output("rst_req", 32'(imem_req), 32'd0);
    check_output("rst_valid", 32'(if_valid), 32'd0);
    check_output("rst_inst", inst, 32'd0);
    check_output("rst_pc", 32'(if_pc), 32'd0);

    // Sequential stream, then a decode stall holding PC 3
    want_rst = 1'b1;
    run_until(3, 40, "stream_progress");
    want_dec_nstall = 1'b0;
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 25'd0);
    check_output("stall_valid", 32'(if_valid), 32'd1);
    check_output("stall_pc", 32'(if_pc), 32'd3);
    check_output("stall_inst", inst, word(25'd3));
    check_output("stall_req", 32'(imem_req), 32'd0);
    want_dec_nstall = 1'b1;
    run_until(8, 40, "resume_progress");

    // Redirect with two requests outstanding at latency 3
    lat = 3;
    begin
      int n = 0;
      while (mem_addr_q.size() != 2 && n < 20) begin
        apply_stimulus(1'b0, 25'd0);
        n++;
      end
      check_output("two_outstanding", 32'(mem_addr_q.size()), 32'd2);
    end
    apply_stimulus(1'b1, 25'h100);
    base = fires;
    run_until(base + 2, 60, "redir_progress");

    // Back-to-back redirects at latency 2
    lat = 2;
    apply_stimulus(1'b1, 25'h40);
    apply_stimulus(1'b1, 25'h80);
    base = fires;
    run_until(base + 3, 60, "b2b_progress");

    // PC wrap with random ack
    lat = 1;
    ack_rand = 1'b1;
    apply_stimulus(1'b1, 25'h1FF_FFFF);
    base = fires;
    run_until(base + 6, 300, "wrap_progress");
    ack_rand = 1'b0;

    // Asynchronous reset with a full buffer
    want_dec_nstall = 1'b0;
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 25'd0);
    check_output("full_valid", 32'(if_valid), 32'd1);
    check_output("full_req", 32'(imem_req), 32'd0);
    #2;
    rst = 1'b0;
    want_rst = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check_output("arst_req", 32'(imem_req), 32'd0);
    check_output("arst_valid", 32'(if_valid), 32'd0);
    check_output("arst_inst", inst, 32'd0);
    check_output("arst_pc", 32'(if_pc), 32'd0);
    mem_addr_q.delete();
    mem_due_q.delete();
    last_due = 0;
    refill(25'd0);
    exp_issue_pc = 25'd0;
    apply_stimulus(1'b0, 25'd0);
    apply_stimulus(1'b0, 25'd0);
    want_rst = 1'b1;
    want_dec_nstall = 1'b1;
    base = fires;
    run_until(base + 3, 40, "post_rst_progress");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
